// File: rtl/layer_argmax.sv
// Sequential argmax over the N signed neuron outputs captured when the layer raises done.
// Latency: accept on cycle T -> out_valid on cycle T+N (N-1 scan cycles plus one output register).
// Backpressure: the result is held in HOLD until out_ready; in_ready stays low until back in IDLE and re-armed.
// Optional ARGMAX_TOP2_EN: adds runner-up tracking with second_idx and margin outputs.
module layer_argmax #(
  parameter int N = 10,
  parameter int W = 16,
  localparam int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        class_idx,
  output logic signed [W-1:0]  max_val,
  output logic                 busy
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IW-1:0]        second_idx,
  output logic signed [W:0]    margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t               state;
  logic                 armed;
  logic signed [W-1:0]  elem_q [N];
  logic [IW-1:0]        ptr;
  logic signed [W-1:0]  best_q;
  logic [IW-1:0]        best_idx_q;
  logic signed [W-1:0]  cand;
  logic signed [W-1:0]  nxt_best;
  logic [IW-1:0]        nxt_idx;
`ifdef ARGMAX_TOP2_EN
  logic signed [W-1:0]  sec_q;
  logic [IW-1:0]        sec_idx_q;
  logic signed [W-1:0]  nxt_sec;
  logic [IW-1:0]        nxt_sec_idx;
`endif

  // A sticky done must not retrigger, so acceptance also needs armed.
  assign in_ready = (state == IDLE) && armed;
  assign busy     = (state != IDLE);

  // Compare the element under the pointer against the running best (strict, so ties keep the lowest index).
  always_comb begin
    cand     = elem_q[ptr];
    nxt_best = best_q;
    nxt_idx  = best_idx_q;
`ifdef ARGMAX_TOP2_EN
    nxt_sec     = sec_q;
    nxt_sec_idx = sec_idx_q;
`endif
    if (cand > best_q) begin
      nxt_best = cand;
      nxt_idx  = ptr;
`ifdef ARGMAX_TOP2_EN
      nxt_sec     = best_q;
      nxt_sec_idx = best_idx_q;
`endif
    end
`ifdef ARGMAX_TOP2_EN
    else if (cand > sec_q) begin
      nxt_sec     = cand;
      nxt_sec_idx = ptr;
    end
`endif
  end

  // Capture / scan / hold state machine with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= 1'b1;
      out_valid  <= 1'b0;
      class_idx  <= '0;
      max_val    <= '0;
      ptr        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      for (int k = 0; k < N; k++) elem_q[k] <= '0;
`ifdef ARGMAX_TOP2_EN
      sec_q      <= '0;
      sec_idx_q  <= '0;
      second_idx <= '0;
      margin     <= '0;
`endif
    end else begin
      // Any cycle with done low re-arms capture.
      if (!in_valid) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid && armed) begin
            for (int k = 0; k < N; k++) elem_q[k] <= in_data[k*W +: W];
            best_q     <= in_data[W-1:0];
            best_idx_q <= '0;
            ptr        <= IW'(1);
            armed      <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_q      <= {1'b1, {(W-1){1'b0}}};
            sec_idx_q  <= '0;
`endif
            state      <= SCAN;
          end
        end
        SCAN: begin
          best_q     <= nxt_best;
          best_idx_q <= nxt_idx;
`ifdef ARGMAX_TOP2_EN
          sec_q      <= nxt_sec;
          sec_idx_q  <= nxt_sec_idx;
`endif
          ptr <= ptr + IW'(1);
          if (ptr == IW'(N-1)) begin
            out_valid <= 1'b1;
            class_idx <= nxt_idx;
            max_val   <= nxt_best;
`ifdef ARGMAX_TOP2_EN
            second_idx <= nxt_sec_idx;
            margin     <= {nxt_best[W-1], nxt_best} - {nxt_sec[W-1], nxt_sec};
`endif
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
